// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
package uart_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] HEADER_BASE_DEF = 8'h30;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      BODY
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after ptr.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   // Scan from the far end so the entry nearest ptr is written last.
   always_comb begin
      idx = '0;
      j   = '0;
      any = |req;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) begin
            idx = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte streams with round-robin,
// packet locking, optional channel header and a burst cap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int               N_REQ       = 4,
   parameter int               HEADER_EN   = 1,
   parameter logic [BYTE_W-1:0] HEADER_BASE = HEADER_BASE_DEF,
   parameter int               MAX_BURST   = 16,
   localparam int              GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int              CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [BYTE_W*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic [GW-1:0]             grant_idx
);

   arb_state_t    state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] pick;
   logic          pick_any;
   logic [CW-1:0] burst_cnt;
   logic          body_xfer;
   logic          at_cap;
   logic          release_grant;

   rr_pick #(
      .N  (N_REQ),
      .IW (GW)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .idx (pick),
      .any (pick_any)
   );

   assign body_xfer = (state == BODY) && req_valid[grant_idx] && tx_ready;
   assign at_cap    = (MAX_BURST != 0) &&
                      (burst_cnt == CW'(MAX_BURST - 1));
   // Last byte and cap on the same transfer collapse into one release.
   assign release_grant = body_xfer && (req_last[grant_idx] || at_cap);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         burst_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_idx <= pick;
                  rr_ptr    <= (pick == GW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                  burst_cnt <= '0;
                  state     <= (HEADER_EN != 0) ? HEADER : BODY;
               end
            end
            HEADER: begin
               if (tx_ready) begin
                  state <= BODY;
               end
            end
            BODY: begin
               if (body_xfer) begin
                  burst_cnt <= burst_cnt + 1'b1;
                  if (release_grant) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      unique case (state)
         HEADER: begin
            tx_valid = 1'b1;
            tx_data  = HEADER_BASE + BYTE_W'(grant_idx);
         end
         BODY: begin
            tx_valid             = req_valid[grant_idx];
            tx_data              = req_data[grant_idx*BYTE_W +: BYTE_W];
            req_ready[grant_idx] = tx_ready;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: randomized requesters,
// per-channel expected byte queues and a packet-level arbitration model.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int CAP  = 4;
   localparam int HBASE = 'h30;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_valid;
   logic           tx_ready;
   logic           busy;
   logic [1:0]     grant_idx;

   uart_tx_arbiter #(
      .N_REQ       (N),
      .HEADER_EN   (1),
      .HEADER_BASE (8'h30),
      .MAX_BURST   (CAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Driver side: bytes waiting to be offered ({last, byte}).
   logic [8:0] drv_q [N][$];
   // Scoreboard side: bytes each channel must deliver, in order.
   logic [8:0] exp_q [N][$];

   int         stall_pct = 0;
   int         rdy_pct   = 100;
   logic [N-1:0] hold_mask = '0;
   bit         mon_en = 1'b0;
   int         phase = 0;
   int         busy_cnt = 0;
   int         grant_log[$];

   task automatic push(input int i, input logic [7:0] b, input bit last);
      drv_q[i].push_back({last, b});
      exp_q[i].push_back({last, b});
   endtask

   initial begin
      logic [N-1:0] fire;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (fire[i]) void'(drv_q[i].pop_front());
            if (drv_q[i].size() > 0 && !hold_mask[i] &&
                int'($urandom_range(99)) >= stall_pct) begin
               req_valid[i]     = 1'b1;
               req_data[i*8+:8] = drv_q[i][0][7:0];
               req_last[i]      = drv_q[i][0][8];
            end else begin
               req_valid[i]     = 1'b0;
               req_data[i*8+:8] = 8'($urandom);
               req_last[i]      = 1'($urandom);
            end
         end
         tx_ready = int'($urandom_range(99)) < rdy_pct;
      end
   end

   // Packet-level reference: who owns the link and what it must send.
   typedef enum int {M_IDLE, M_HDR, M_BODY} mstate_t;
   mstate_t ms = M_IDLE;
   int m_ptr = 0;
   int m_g   = 0;
   int m_cnt = 0;

   always @(negedge clk) begin
      logic [8:0] e;
      if (phase == 1 && busy) busy_cnt++;
      if (rst_n && mon_en) begin
         chk("busy", 32'(busy), 32'(ms != M_IDLE));
         if (ms == M_IDLE) begin
            chk("idle_tx_valid", 32'(tx_valid), 0);
            chk("idle_tx_data", 32'(tx_data), 0);
            chk("idle_req_ready", 32'(req_ready), 0);
            if (req_valid != '0) begin
               for (int k = 0; k < N; k++) begin
                  if (req_valid[2'((m_ptr + k) % N)]) begin
                     m_g = (m_ptr + k) % N;
                     break;
                  end
               end
               grant_log.push_back(m_g);
               m_ptr = (m_g + 1) % N;
               m_cnt = 0;
               ms    = M_HDR;
            end
         end else if (ms == M_HDR) begin
            chk("hdr_grant", 32'(grant_idx), m_g);
            chk("hdr_tx_valid", 32'(tx_valid), 1);
            chk("hdr_tx_data", 32'(tx_data), HBASE + m_g);
            chk("hdr_req_ready", 32'(req_ready), 0);
            if (tx_ready) ms = M_BODY;
         end else begin
            chk("body_grant", 32'(grant_idx), m_g);
            chk("body_tx_valid", 32'(tx_valid), 32'(req_valid[2'(m_g)]));
            chk("body_req_ready", 32'(req_ready),
                tx_ready ? (1 << m_g) : 0);
            if (tx_valid && tx_ready) begin
               if (exp_q[m_g].size() == 0) begin
                  chk("body_unexpected", exp_q[m_g].size(), 1);
                  ms = M_IDLE;
               end else begin
                  e = exp_q[m_g].pop_front();
                  chk("body_byte", 32'(tx_data), 32'(e[7:0]));
                  m_cnt++;
                  if (e[8] || m_cnt == CAP) ms = M_IDLE;
               end
            end
         end
      end
   end

   task automatic wait_drain(input int budget);
      int left;
      int n;
      n = 0;
      forever begin
         left = 0;
         for (int i = 0; i < N; i++) left += exp_q[i].size();
         if ((left == 0 && ms == M_IDLE) || n >= budget) break;
         @(posedge clk);
         n++;
      end
      chk("drain_left", left, 0);
   endtask

   initial begin
      int g0;
      int n;
      int len;
      int r;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_idx), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      mon_en = 1'b1;

      // Single requester, link always ready.
      phase = 1;
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b1);
      wait_drain(200);
      phase = 0;
      chk("single_busy_cycles", busy_cnt, 3);

      // Everyone valid with one-byte packets; pointer now sits at 2.
      g0 = grant_log.size();
      for (int rep = 0; rep < 2; rep++)
         for (int i = 0; i < N; i++) push(i, 8'($urandom), 1'b1);
      wait_drain(300);
      chk("rr_grant_count", grant_log.size() - g0, 8);
      if (grant_log.size() - g0 == 8)
         for (int k = 0; k < 8; k++)
            chk("rr_order", grant_log[g0 + k], (2 + k) % N);

      // Randomized traffic with stalls and backpressure.
      stall_pct = 25;
      rdy_pct   = 60;
      for (int c = 0; c < 5; c++) begin
         for (int p = 0; p < 30; p++) begin
            r   = int'($urandom_range(N - 1));
            len = int'($urandom_range(7, 1));
            for (int b = 0; b < len; b++)
               push(r, 8'($urandom), b == len - 1);
         end
         repeat (int'($urandom_range(200, 20))) @(posedge clk);
      end
      wait_drain(20000);

      // Granted channel stalls mid-packet while another waits.
      stall_pct = 0;
      rdy_pct   = 100;
      push(0, 8'h41, 1'b0);
      push(0, 8'h42, 1'b0);
      push(0, 8'h43, 1'b1);
      n = 0;
      while (!(ms == M_BODY && m_g == 0 && m_cnt == 1) && n < 500) begin
         @(posedge clk);
         n++;
      end
      hold_mask[0] = 1'b1;
      chk("stall_setup", 32'(n < 500), 1);
      push(1, 8'h55, 1'b0);
      push(1, 8'h56, 1'b1);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_grant", 32'(grant_idx), 0);
         chk("stall_tx_valid", 32'(tx_valid), 0);
      end
      hold_mask[0] = 1'b0;
      wait_drain(500);

      // Reset in the middle of a body with the link toggling.
      rdy_pct = 50;
      for (int b = 0; b < 6; b++) push(1, 8'($urandom), b == 5);
      n = 0;
      while (!(ms == M_BODY && m_cnt >= 1) && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("reset_setup", 32'(n < 500), 1);
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("midrst_tx_valid", 32'(tx_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_grant", 32'(grant_idx), 0);
      chk("midrst_req_ready", 32'(req_ready), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
